dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, memory address width.
REQ-002 Parameter WDATA_W, default 128, write-data width.
REQ-003 Parameter RDATA_W, default 64, read-data width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rN_req_valid  input  1  requester N (N=0,1) has a request.
REQ-007 rN_req_ready  output  1  request of requester N accepted this cycle when valid.
REQ-008 rN_req_we  input  1  1 = write, 0 = read.
REQ-009 rN_req_addr  input  ADDR_W  byte address.
REQ-010 rN_req_wdata  input  WDATA_W  write data.
REQ-011 rN_rsp_valid  output  1  response for requester N available.
REQ-012 rN_rsp_ready  input  1  requester N consumes response.
REQ-013 rN_rsp_rdata  output  RDATA_W  read data; 0 for writes and errors.
REQ-014 rN_rsp_err  output  1  request rejected (misaligned).
REQ-015 mem_en  output  1  datamem enable.
REQ-016 mem_write_en, mem_read_en  output  1 each  datamem write/read strobes.
REQ-017 mem_address  output  ADDR_W  datamem address.
REQ-018 mem_write_data  output  WDATA_W  datamem write data.
REQ-019 mem_read_data  input  RDATA_W  datamem read data, valid combinationally in the cycle mem_read_en is high.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; exactly one request in flight.
REQ-021 IDLE: rN_req_ready = 1 only for the granted requester N; the other's ready = 0; ready = 0 in ISSUE and RESP.
REQ-022 Grant: one valid → that one; both valid → requester indicated by round-robin pointer rr_ptr.
REQ-023 Accept (valid && ready in IDLE): latch owner, we, addr, wdata; aligned → ISSUE; misaligned → RESP with err.
REQ-024 Misaligned = addr[2:0] != 0; no memory strobe is driven for it.
REQ-025 ISSUE (exactly one cycle): mem_en = 1, mem_write_en = we, mem_read_en = !we, mem_address/mem_write_data from latch; read data registered at end of cycle; → RESP.
REQ-026 Outside ISSUE: mem_en, strobes, mem_address, mem_write_data all 0.
REQ-027 RESP: owner's rsp_valid = 1 with stable rdata/err until rsp_ready; the other requester's rsp_valid = 0.
REQ-028 RESP with rsp_ready: → IDLE next cycle; rr_ptr set to the non-owner.
REQ-029 Latency: accept at cycle T, memory access T+1, rsp_valid from T+2; maximum throughput one request per 3 cycles.
REQ-030 rsp_rdata = 0 and rsp_err = 0 for writes; rdata = 0, err = 1 for misaligned.
REQ-031 Requests arriving while busy stall with ready = 0; requesters hold valid and payload.
REQ-032 No starvation: with both continuously valid, grants strictly alternate.

Reset
REQ-033 rst_n low: state = IDLE, rr_ptr = 0, latches = 0, all outputs 0 immediately (asynchronous).
REQ-034 Reset mid-ISSUE or mid-RESP aborts the transaction; no response is produced and memory strobes drop asynchronously.

Structure
REQ-035 Package dmem_arb_pkg holds the state enum, default widths and the alignment mask constant.
REQ-036 Sub-module dmem_rr_pick: combinational 2-way round-robin select (valids, rr_ptr → grant one-hot).

Verification
REQ-037 r0 write addr 0x40, wdata 0xA3 → ISSUE cycle: mem_en=1, mem_write_en=1, mem_address=0x40; r0_rsp_valid at T+2, err=0, rdata=0.
REQ-038 r1 read addr 0x40, mem_read_data=0xA3 → r1_rsp_rdata=0xA3 at T+2, held until r1_rsp_ready.
REQ-039 Both valid continuously from reset → grants r0, r1, r0, r1; no back-to-back grant to one requester.
REQ-040 r0 read addr 0x43 → r0_rsp_err=1, rdata=0, mem_en never asserted.
REQ-041 rsp_ready held 0 for 5 cycles in RESP → rsp_valid/rdata stable, no new accept, r1_req_ready=0 throughout.
REQ-042 rst_n driven low during ISSUE of a write → mem_write_en falls without a clock edge; after release state IDLE, rr_ptr=0, no rsp_valid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_WDATA_W = 128;
    localparam int DEF_RDATA_W = 64;

    // Accesses must be 8-byte aligned; any set bit under this mask is a reject.
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    function automatic logic is_misaligned(input logic [2:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response handshakes of both requesters plus the datamem port.
// Latency: n/a (wires only).
// Backpressure: valid/ready on requests and responses; memory port has none.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WDATA_W = DEF_WDATA_W,
    parameter int RDATA_W = DEF_RDATA_W
) ();
    logic               r0_req_valid;
    logic               r0_req_ready;
    logic               r0_req_we;
    logic [ADDR_W-1:0]  r0_req_addr;
    logic [WDATA_W-1:0] r0_req_wdata;
    logic               r0_rsp_valid;
    logic               r0_rsp_ready;
    logic [RDATA_W-1:0] r0_rsp_rdata;
    logic               r0_rsp_err;

    logic               r1_req_valid;
    logic               r1_req_ready;
    logic               r1_req_we;
    logic [ADDR_W-1:0]  r1_req_addr;
    logic [WDATA_W-1:0] r1_req_wdata;
    logic               r1_rsp_valid;
    logic               r1_rsp_ready;
    logic [RDATA_W-1:0] r1_rsp_rdata;
    logic               r1_rsp_err;

    logic               mem_en;
    logic               mem_write_en;
    logic               mem_read_en;
    logic [ADDR_W-1:0]  mem_address;
    logic [WDATA_W-1:0] mem_write_data;
    logic [RDATA_W-1:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  r0_req_valid, r0_req_we, r0_req_addr, r0_req_wdata, r0_rsp_ready,
        output r0_req_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        input  r1_req_valid, r1_req_we, r1_req_addr, r1_req_wdata, r1_rsp_ready,
        output r1_req_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        output mem_en, mem_write_en, mem_read_en, mem_address, mem_write_data,
        input  mem_read_data
    );

    // Requester / memory-model side.
    modport master (
        output r0_req_valid, r0_req_we, r0_req_addr, r0_req_wdata, r0_rsp_ready,
        input  r0_req_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        output r1_req_valid, r1_req_we, r1_req_addr, r1_req_wdata, r1_rsp_ready,
        input  r1_req_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        input  mem_en, mem_write_en, mem_read_en, mem_address, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin select: valids plus priority pointer to a one-hot grant.
// Latency: combinational.
// Backpressure: none; grant is zero when nobody is valid.
module dmem_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_rr_ptr,
    output logic [1:0] o_grant
);

    // A lone valid always wins; on a tie the pointer names the winner.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-cycle datamem, one request in flight.
// Latency: accept T, memory access T+1, response from T+2 (misaligned: T+1).
// Backpressure: req ready only in IDLE; response held until the owner's rsp_ready.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WDATA_W = DEF_WDATA_W,
    parameter int RDATA_W = DEF_RDATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rr_ptr;
    logic               r_owner;
    logic               r_we;
    logic               r_err;
    logic [ADDR_W-1:0]  r_addr;
    logic [WDATA_W-1:0] r_wdata;
    logic [RDATA_W-1:0] r_rdata;

    logic [1:0]         w_valid;
    logic [1:0]         w_grant;
    logic [1:0]         w_ready;
    logic [1:0]         w_rsp_valid;
    logic               w_accept;
    logic               w_rsp_done;
    logic               w_req_we;
    logic [ADDR_W-1:0]  w_req_addr;
    logic [WDATA_W-1:0] w_req_wdata;
    logic               w_misaligned;
    logic               w_mem_en;
    logic               w_own_rsp_ready;

    assign w_valid = {bus.r1_req_valid, bus.r0_req_valid};

    dmem_rr_pick u_pick (
        .i_valid  (w_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant)
    );

    // Payload of whichever requester holds the grant.
    assign w_req_we     = w_grant[1] ? bus.r1_req_we    : bus.r0_req_we;
    assign w_req_addr   = w_grant[1] ? bus.r1_req_addr  : bus.r0_req_addr;
    assign w_req_wdata  = w_grant[1] ? bus.r1_req_wdata : bus.r0_req_wdata;
    assign w_misaligned = is_misaligned(w_req_addr[2:0]);
    assign w_own_rsp_ready = r_owner ? bus.r1_rsp_ready : bus.r0_rsp_ready;

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake/strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 2'b00;
        w_rsp_valid  = 2'b00;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        w_mem_en     = 1'b0;
        case (r_state)
            IDLE: begin
                // rst_n gating keeps ready low while reset is asserted.
                w_ready  = w_grant & {2{rst_n}};
                w_accept = |(w_ready & w_valid);
                if (w_accept) begin
                    w_next_state = w_misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_mem_en     = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (w_own_rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, read-data capture and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant[1];
                r_we    <= w_req_we;
                r_addr  <= w_req_addr;
                r_wdata <= w_req_wdata;
                r_err   <= w_misaligned;
                r_rdata <= '0;
            end
            if (r_state == ISSUE) begin
                r_rdata <= r_we ? '0 : bus.mem_read_data;
            end
            if (w_rsp_done) begin
                r_rr_ptr <= ~r_owner;
            end
        end
    end

    assign bus.r0_req_ready   = w_ready[0];
    assign bus.r1_req_ready   = w_ready[1];
    assign bus.r0_rsp_valid   = w_rsp_valid[0];
    assign bus.r1_rsp_valid   = w_rsp_valid[1];
    assign bus.r0_rsp_rdata   = w_rsp_valid[0] ? r_rdata : '0;
    assign bus.r1_rsp_rdata   = w_rsp_valid[1] ? r_rdata : '0;
    assign bus.r0_rsp_err     = w_rsp_valid[0] & r_err;
    assign bus.r1_rsp_err     = w_rsp_valid[1] & r_err;

    assign bus.mem_en         = w_mem_en;
    assign bus.mem_write_en   = w_mem_en & r_we;
    assign bus.mem_read_en    = w_mem_en & ~r_we;
    assign bus.mem_address    = w_mem_en ? r_addr  : '0;
    assign bus.mem_write_data = w_mem_en ? r_wdata : '0;

endmodule
